input_buffer: RTL and testbench



---
 rtl/input_buffer.sv | 112 +++++++++++
 tb/tb_input_buffer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/input_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | input_buffer : per-port packet FIFO, first-word-fall-through head output.  |
// | Optional same-cycle bypass when empty: define INPUT_BUFFER_BYPASS_EN.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+

package input_buffer_pkg;
  typedef struct packed {
    logic [3:0]  dest;
    logic [11:0] data;
  } pkt_t;
endpackage

module input_buffer
  import input_buffer_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          put_inbound,
  input  pkt_t          payload_inbound,
  output logic          free_inbound,
  input  logic          read_from_ib,
  output logic          pkt_avail,
  output pkt_t          pkt_out,
  output logic [CW-1:0] count,
  output logic          overflow_err,
  output logic          underflow_err
);

  localparam int AW = $clog2(DEPTH);

  pkt_t          r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [CW-1:0] r_count;
  logic          r_ovf;
  logic          r_unf;

  logic w_empty;
  logic w_free;
  logic w_avail;
  logic w_byp;
  logic w_byp_consume;
  logic w_wr;
  logic w_rd;
  pkt_t w_out;

  assign w_empty = (r_count == '0);
  assign w_free  = (r_count != CW'(DEPTH));

`ifdef INPUT_BUFFER_BYPASS_EN
  assign w_byp = w_empty & put_inbound;
`else
  assign w_byp = 1'b0;
`endif

  assign w_avail       = ~w_empty | w_byp;
  // A bypassed packet that is read in the same cycle never touches storage.
  assign w_byp_consume = w_byp & read_from_ib;
  assign w_wr          = put_inbound & w_free & ~w_byp_consume;
  assign w_rd          = read_from_ib & w_avail & ~w_byp_consume;

  always_comb begin
    w_out = '0;
    if (!w_empty)
      w_out = r_mem[r_rp];
    else if (w_byp)
      w_out = payload_inbound;
  end

  always_ff @(posedge clock) begin
    if (w_wr)
      r_mem[r_wp] <= payload_inbound;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      if (w_wr)
        r_wp <= r_wp + AW'(1);
      if (w_rd)
        r_rp <= r_rp + AW'(1);
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (put_inbound && !w_free)
        r_ovf <= 1'b1;
      if (read_from_ib && !w_avail)
        r_unf <= 1'b1;
    end
  end

  assign free_inbound  = w_free;
  assign pkt_avail     = w_avail;
  assign pkt_out       = w_out;
  assign count         = r_count;
  assign overflow_err  = r_ovf;
  assign underflow_err = r_unf;

endmodule
`default_nettype wire

// File: tb/tb_input_buffer.sv
`default_nettype none
// Testbench for input_buffer: vector table for fill/drain/error flags, plus
// hand sequences for async reset, wrap streaming, put+read at full, bypass.
module tb_input_buffer;
  import input_buffer_pkg::*;

`ifdef INPUT_BUFFER_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       put_inbound = 1'b0;
  pkt_t       payload_inbound = '0;
  logic       free_inbound;
  logic       read_from_ib = 1'b0;
  logic       pkt_avail;
  pkt_t       pkt_out;
  logic [2:0] count;
  logic       overflow_err;
  logic       underflow_err;

  int n_checks = 0;
  int n_errors = 0;

  input_buffer #(.DEPTH(4)) dut (
    .clock(clock), .reset_n(reset_n),
    .put_inbound(put_inbound), .payload_inbound(payload_inbound),
    .free_inbound(free_inbound), .read_from_ib(read_from_ib),
    .pkt_avail(pkt_avail), .pkt_out(pkt_out), .count(count),
    .overflow_err(overflow_err), .underflow_err(underflow_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        put;
    logic [15:0] pl;
    logic        rd;
    logic [2:0]  cnt;
    logic        fr;
    logic        av;
    logic [15:0] out;
    logic        ov;
    logic        un;
  } vec_t;

  vec_t tbl [14];

  function automatic logic [15:0] mk(input int d);
    pkt_t p;
    p.dest = 4'(d);
    p.data = 12'hA00 + 12'(d);
    return p;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic p, input logic [15:0] pl, input logic r);
    @(negedge clock);
    put_inbound     = p;
    payload_inbound = pl;
    read_from_ib    = r;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    put_inbound  = 1'b0;
    read_from_ib = 1'b0;
    reset_n      = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic set_row(input int i, input logic p, input int d, input logic r,
                         input logic [2:0] c, input logic f, input logic a,
                         input logic [15:0] o, input logic ov, input logic un);
    tbl[i] = '{p, (p ? mk(d) : 16'h0), r, c, f, a, o, ov, un};
  endtask

  initial begin
    // Rows check outputs during the cycle, before the edge that commits inputs.
    set_row(0,  0, 0, 0, 3'd0, 1, 0,   16'h0,          0, 0);
    set_row(1,  1, 0, 0, 3'd0, 1, BYP, BYP ? mk(0) : 16'h0, 0, 0);
    set_row(2,  1, 1, 0, 3'd1, 1, 1,   mk(0),          0, 0);
    set_row(3,  1, 2, 0, 3'd2, 1, 1,   mk(0),          0, 0);
    set_row(4,  1, 3, 0, 3'd3, 1, 1,   mk(0),          0, 0);
    set_row(5,  1, 4, 0, 3'd4, 0, 1,   mk(0),          0, 0);
    set_row(6,  0, 0, 0, 3'd4, 0, 1,   mk(0),          1, 0);
    set_row(7,  0, 0, 1, 3'd4, 0, 1,   mk(0),          1, 0);
    set_row(8,  0, 0, 1, 3'd3, 1, 1,   mk(1),          1, 0);
    set_row(9,  0, 0, 1, 3'd2, 1, 1,   mk(2),          1, 0);
    set_row(10, 0, 0, 1, 3'd1, 1, 1,   mk(3),          1, 0);
    set_row(11, 0, 0, 0, 3'd0, 1, 0,   16'h0,          1, 0);
    set_row(12, 0, 0, 1, 3'd0, 1, 0,   16'h0,          1, 0);
    set_row(13, 0, 0, 0, 3'd0, 1, 0,   16'h0,          1, 1);

    do_reset();
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].put, tbl[i].pl, tbl[i].rd);
      chk($sformatf("row%0d count", i), 32'(count), 32'(tbl[i].cnt));
      chk($sformatf("row%0d free", i), 32'(free_inbound), 32'(tbl[i].fr));
      chk($sformatf("row%0d avail", i), 32'(pkt_avail), 32'(tbl[i].av));
      chk($sformatf("row%0d pkt_out", i), 32'(pkt_out), 32'(tbl[i].out));
      chk($sformatf("row%0d ovf", i), 32'(overflow_err), 32'(tbl[i].ov));
      chk($sformatf("row%0d unf", i), 32'(underflow_err), 32'(tbl[i].un));
    end

    // Asynchronous reset mid-stream, asserted between edges.
    do_reset();
    for (int i = 0; i < 3; i++) drive(1'b1, mk(i + 7), 1'b0);
    drive(1'b0, 16'h0, 1'b0);
    chk("prereset count", 32'(count), 32'd3);
    #2 reset_n = 1'b0;
    #1;
    chk("arst count", 32'(count), 32'd0);
    chk("arst free", 32'(free_inbound), 32'd1);
    chk("arst avail", 32'(pkt_avail), 32'd0);
    chk("arst pkt_out", 32'(pkt_out), 32'd0);
    chk("arst errs", 32'({overflow_err, underflow_err}), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    // Wrap-around streaming: occupancy held at 1 for ten packets.
    drive(1'b1, mk(0), 1'b0);
    for (int i = 1; i <= 10; i++) begin
      drive(i < 10, (i < 10) ? mk(i) : 16'h0, 1'b1);
      chk($sformatf("wrap%0d count", i), 32'(count), 32'd1);
      chk($sformatf("wrap%0d out", i), 32'(pkt_out), 32'(mk(i - 1)));
    end
    drive(1'b0, 16'h0, 1'b0);
    chk("wrap end count", 32'(count), 32'd0);
    chk("wrap errs", 32'({overflow_err, underflow_err}), 32'd0);

    // Put and read together while full: put rejected, count drops to 3.
    do_reset();
    for (int i = 0; i < 4; i++) drive(1'b1, mk(i), 1'b0);
    drive(1'b1, mk(9), 1'b1);
    chk("full+rd free", 32'(free_inbound), 32'd0);
    chk("full+rd count", 32'(count), 32'd4);
    drive(1'b0, 16'h0, 1'b0);
    chk("after full+rd count", 32'(count), 32'd3);
    chk("after full+rd free", 32'(free_inbound), 32'd1);
    chk("after full+rd ovf", 32'(overflow_err), 32'd1);
    chk("after full+rd out", 32'(pkt_out), 32'(mk(1)));
    for (int i = 1; i < 4; i++) begin
      drive(1'b0, 16'h0, 1'b1);
      chk($sformatf("drain%0d out", i), 32'(pkt_out), 32'(mk(i)));
    end
    drive(1'b0, 16'h0, 1'b0);
    chk("drain end avail", 32'(pkt_avail), 32'd0);

    // Put dest=5 into an empty buffer with a same-cycle read.
    do_reset();
    drive(1'b1, mk(5), 1'b1);
    chk("byp avail", 32'(pkt_avail), 32'(BYP));
    chk("byp out", 32'(pkt_out), BYP ? 32'(mk(5)) : 32'd0);
    drive(1'b0, 16'h0, 1'b0);
    chk("byp next count", 32'(count), BYP ? 32'd0 : 32'd1);
    chk("byp next avail", 32'(pkt_avail), BYP ? 32'd0 : 32'd1);
    chk("byp unf", 32'(underflow_err), BYP ? 32'd0 : 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
`default_nettype wire
